// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: NREQ requesters share one bin->gray / gray->bin converter pair behind a round-robin arbiter.
// Define GRAY_ARB_FIXED_PRIO_EN to switch the arbiter to fixed priority, where the lowest index wins.
module gray_conv_arbiter #(
  parameter int BIT  = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_mode,
  input  logic [NREQ*BIT-1:0] i_data,
  output logic [NREQ-1:0]   o_gnt,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic              o_rsp_mode,
  output logic [BIT-1:0]    o_rsp_data,
  input  logic              i_rsp_ready,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic rsp_mode_q, rsp_mode_d;
  logic [BIT-1:0] rsp_data_q, rsp_data_d;
  logic [BIT-1:0] word_q, word_d;
  logic mode_q, mode_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] win;
  logic hit;
  function automatic logic [BIT-1:0] b2g(input logic [BIT-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [BIT-1:0] g2b(input logic [BIT-1:0] g);
    logic [BIT-1:0] b;
    b[BIT-1] = g[BIT-1];
    for (int k = BIT-2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction
`ifdef GRAY_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    hit = |i_req;
    for (int i = NREQ-1; i >= 0; i--) if (i_req[i]) win = IDW'(i);
  end
`else
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] idx;
  // search upward from the slot after the last winner, wrapping at NREQ
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (!hit && i_req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  always_comb last_d = (state_q == IDLE && hit) ? win : last_q;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) last_q <= IDW'(NREQ-1);
    else last_q <= last_d;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_mode_d = rsp_mode_q;
    rsp_data_d = rsp_data_q;
    word_d = word_q;
    mode_d = mode_q;
    id_d = id_q;
    case (state_q)
      IDLE: if (hit) begin
        state_d = CONV;
        gnt_d = NREQ'(1) << win;
        word_d = i_data[int'(win)*BIT +: BIT];
        mode_d = i_mode[win];
        id_d = win;
      end
      CONV: begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d = mode_q ? g2b(word_q) : b2g(word_q);
        rsp_id_d = id_q;
        rsp_mode_d = mode_q;
      end
      RESP: if (i_rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_mode_q <= 1'b0;
      rsp_data_q <= '0;
      word_q <= '0;
      mode_q <= 1'b0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_mode_q <= rsp_mode_d;
      rsp_data_q <= rsp_data_d;
      word_q <= word_d;
      mode_q <= mode_d;
      id_q <= id_d;
    end
  assign o_gnt = gnt_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id = rsp_id_q;
  assign o_rsp_mode = rsp_mode_q;
  assign o_rsp_data = rsp_data_q;
  assign o_busy = state_q != IDLE;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed tests of the shared converter arbiter, default build plus a BIT=16/NREQ=3 instance.
module tb_gray_conv_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic [3:0] req, mode, gnt;
  logic [31:0] data;
  logic rdy, vld, rmode, busy;
  logic [1:0] rid;
  logic [7:0] rdata;
  logic [2:0] req16, mode16, gnt16;
  logic [47:0] data16;
  logic vld16, rmode16, busy16;
  logic [1:0] rid16;
  logic [15:0] rdata16;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gray_conv_arbiter dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_mode(mode), .i_data(data),
    .o_gnt(gnt), .o_rsp_valid(vld), .o_rsp_id(rid), .o_rsp_mode(rmode),
    .o_rsp_data(rdata), .i_rsp_ready(rdy), .o_busy(busy)
  );

  gray_conv_arbiter #(.BIT(16), .NREQ(3), .IDW(2)) dut16 (
    .i_clk(clk), .i_rstn(rstn), .i_req(req16), .i_mode(mode16), .i_data(data16),
    .o_gnt(gnt16), .o_rsp_valid(vld16), .o_rsp_id(rid16), .o_rsp_mode(rmode16),
    .o_rsp_data(rdata16), .i_rsp_ready(1'b1), .o_busy(busy16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_b2g(input logic [15:0] b, input int w);
    logic [15:0] g = '0;
    for (int k = 0; k < w-1; k++) g[k] = b[k+1] ^ b[k];
    g[w-1] = b[w-1];
    return g;
  endfunction

  function automatic logic [15:0] ref_g2b(input logic [15:0] g, input int w);
    logic [15:0] b = '0;
    logic acc = 1'b0;
    for (int k = w-1; k >= 0; k--) begin
      acc = acc ^ g[k];
      b[k] = acc;
    end
    return b;
  endfunction

  task automatic test_reset;
    rstn = 1'b0; req = '0; mode = '0; data = '0; rdy = 1'b1;
    req16 = '0; mode16 = '0; data16 = '0;
    tick; tick;
    total++;
    if ({gnt, vld, rid, rmode, rdata, busy} !== 17'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {gnt, vld, rid, rmode, rdata, busy});
    end
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_b2g;
    req = 4'b0001; mode = 4'b0000; data[7:0] = 8'h2D;
    tick;
    total++;
    if (gnt !== 4'b0001 || vld !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2g_grant got gnt=%b vld=%b busy=%b exp gnt=0001 vld=0 busy=1", gnt, vld, busy);
    end
    req = '0;
    tick;
    total++;
    if (gnt !== 4'b0 || vld !== 1'b1 || rdata !== 8'h3B || rid !== 2'd0 || rmode !== 1'b0) begin
      bad++;
      $display("FAIL b2g_rsp got gnt=%b vld=%b data=%h id=%0d mode=%b exp 0000 1 3b 0 0", gnt, vld, rdata, rid, rmode);
    end
    tick;
    total++;
    if (vld !== 1'b0 || busy !== 1'b0 || rdata !== 8'h3B) begin
      bad++;
      $display("FAIL b2g_done got vld=%b busy=%b data=%h exp 0 0 3b", vld, busy, rdata);
    end
  endtask

  task automatic test_g2b;
    req = 4'b0100; mode = 4'b0100; data[23:16] = 8'h3B;
    tick;
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL g2b_grant got=%b exp=0100", gnt);
    end
    req = '0;
    tick;
    total++;
    if (vld !== 1'b1 || rdata !== 8'h2D || rid !== 2'd2 || rmode !== 1'b1) begin
      bad++;
      $display("FAIL g2b_rsp got vld=%b data=%h id=%0d mode=%b exp 1 2d 2 1", vld, rdata, rid, rmode);
    end
    tick;
  endtask

  task automatic test_round_robin;
    int ord[5];
    logic [3:0] exp;
`ifdef GRAY_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    rstn = 1'b0;
    tick;
    rstn = 1'b1; rdy = 1'b1; mode = '0; data = 32'h44332211;
    req = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      tick;
      exp = (c % 3 == 0) ? (4'b0001 << ord[c/3]) : 4'b0000;
      total++;
      if (gnt !== exp) begin
        bad++;
        $display("FAIL rr_cycle%0d got=%b exp=%b", c, gnt, exp);
      end
    end
    req = '0;
    tick; tick;
    total++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got busy=%b vld=%b exp 0 0", busy, vld);
    end
  endtask

  task automatic test_back_pressure;
    rdy = 1'b0; mode = '0; data[15:8] = 8'hFF;
    req = 4'b0010;
    tick;
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL bp_grant got=%b exp=0010", gnt);
    end
    req = 4'b1000;
    data[15:8] = 8'h00;
    tick;
    for (int c = 0; c < 5; c++) begin
      tick;
      total++;
      if (vld !== 1'b1 || rdata !== 8'h80 || rid !== 2'd1 || gnt !== 4'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d got vld=%b data=%h id=%0d gnt=%b busy=%b exp 1 80 1 0000 1", c, vld, rdata, rid, gnt, busy);
      end
    end
    rdy = 1'b1;
    tick;
    total++;
    if (vld !== 1'b0 || gnt !== 4'b0 || rdata !== 8'h80) begin
      bad++;
      $display("FAIL bp_release got vld=%b gnt=%b data=%h exp 0 0000 80", vld, gnt, rdata);
    end
    tick;
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL bp_next_grant got=%b exp=1000", gnt);
    end
    req = '0;
    tick; tick;
  endtask

  task automatic test_async_reset;
    req = 4'b0001; mode = '0; data[7:0] = 8'h5A;
    tick;
    req = '0;
    total++;
    if (busy !== 1'b1 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL ar_in_conv got busy=%b gnt=%b exp 1 0001", busy, gnt);
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({gnt, vld, rid, rmode, rdata, busy} !== 17'h0) begin
      bad++;
      $display("FAIL ar_immediate got=%h exp=0", {gnt, vld, rid, rmode, rdata, busy});
    end
    tick;
    rstn = 1'b1;
    total++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ar_discard got vld=%b busy=%b exp 0 0", vld, busy);
    end
    req = 4'b0010;
    tick;
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL ar_after_grant got=%b exp=0010", gnt);
    end
    req = '0;
    tick; tick;
  endtask

  task automatic test_sweep;
    logic [7:0] exp;
    rdy = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        mode = {3'b000, m[0]}; data[7:0] = v[7:0]; req = 4'b0001;
        exp = m[0] ? ref_g2b({8'h00, v[7:0]}, 8)[7:0] : ref_b2g({8'h00, v[7:0]}, 8)[7:0];
        tick;
        req = '0;
        tick;
        total++;
        if (vld !== 1'b1 || rdata !== exp || rmode !== m[0] || rid !== 2'd0) begin
          bad++;
          $display("FAIL sweep_m%0d_v%02h got vld=%b data=%h mode=%b id=%0d exp data=%h", m, v, vld, rdata, rmode, rid, exp);
        end
        tick;
      end
    end
  endtask

  task automatic test_wide;
    logic [15:0] vin[4];
    logic [15:0] vexp[4];
    logic mv[4];
    vin = '{16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF};
    mv = '{1'b0, 1'b1, 1'b0, 1'b1};
    vexp = '{16'h8000, 16'hFFFF, 16'hC000, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      mode16 = {mv[i], 2'b00}; data16[47:32] = vin[i]; req16 = 3'b100;
      tick;
      total++;
      if (gnt16 !== 3'b100) begin
        bad++;
        $display("FAIL wide_grant%0d got=%b exp=100", i, gnt16);
      end
      req16 = '0;
      tick;
      total++;
      if (vld16 !== 1'b1 || rdata16 !== vexp[i] || rid16 !== 2'd2 || rmode16 !== mv[i]) begin
        bad++;
        $display("FAIL wide_rsp%0d got vld=%b data=%h id=%0d mode=%b exp data=%h", i, vld16, rdata16, rid16, rmode16, vexp[i]);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_b2g;
    test_g2b;
    test_round_robin;
    test_back_pressure;
    test_async_reset;
    test_sweep;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
